// File: rtl/cpu6_bus_arbiter_pkg.sv
// Shared types for the CPU6 bus arbiter: FSM states, bus owner encoding and
// the read data returned on a timed-out access.
package cpu6_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } busState_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_t;

    localparam logic [7:0] ERR_DATA = 8'hFF;

    // On a tie the port that did not own the last completed access wins.
    function automatic owner_t pickOwner(input logic cpuReq, input logic dmaReq,
                                         input owner_t lastOwner);
        if (cpuReq && dmaReq) begin
            return (lastOwner == OWNER_DMA) ? OWNER_CPU : OWNER_DMA;
        end else if (cpuReq) begin
            return OWNER_CPU;
        end else begin
            return OWNER_DMA;
        end
    endfunction

endpackage

// File: rtl/cpu6_bus_timer.sv
// Access timer: wait-state countdown that saturates at zero, plus a cycle
// counter that flags when an access has run out of time.
module cpu6_bus_timer #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic waitDone,
    output logic timeout
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [3:0]      waitCnt;
    logic [TO_W-1:0] toCnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            waitCnt <= '0;
            toCnt   <= '0;
        end else if (load) begin
            waitCnt <= 4'(WAIT_STATES);
            toCnt   <= '0;
        end else if (enable) begin
            if (waitCnt != 4'd0) begin
                waitCnt <= waitCnt - 4'd1;
            end
            // Holding at the limit keeps the flag stable if the FSM lingers.
            if (!timeout) begin
                toCnt <= toCnt + 1'b1;
            end
        end
    end

    assign waitDone = (waitCnt == 4'd0);
    assign timeout  = (toCnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu6_bus_arbiter.sv
// CPU6 memory bus arbiter: round-robin between CPU and DMA, then sequences the
// granted access through wait states, device ready and timeout.
//
//   state  | meaning
//   IDLE   | bus free, arbitrate and latch the winner's request
//   ACCESS | strobes active, waiting for wait states and mem_ready
//   DONE   | one-cycle ready or err pulse to the owner, grant still held
module cpu6_bus_arbiter
    import cpu6_bus_arbiter_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic        cpu_grant,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic [7:0]  dma_rdata,
    output logic        dma_ready,
    output logic        dma_err,
    output logic        dma_grant,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata
);

    busState_t state, stateNext;
    owner_t    owner, lastOwner, reqOwner;
    logic      accWe;
    logic      errFlag;
    logic      grantNow, complete, abort;
    logic      waitDone, timeout;
    logic      busy;

    cpu6_bus_timer #(
        .WAIT_STATES(WAIT_STATES),
        .TIMEOUT    (TIMEOUT)
    ) timer (
        .clock   (clock),
        .reset   (reset),
        .load    (grantNow),
        .enable  (state == ACCESS),
        .waitDone(waitDone),
        .timeout (timeout)
    );

    always_comb begin
        stateNext = state;
        grantNow  = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        reqOwner  = pickOwner(cpu_req, dma_req, lastOwner);
        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grantNow  = 1'b1;
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                // A device that answers on the last allowed cycle still completes.
                if (waitDone && mem_ready) begin
                    complete  = 1'b1;
                    stateNext = DONE;
                end else if (timeout) begin
                    abort     = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWNER_CPU;
            lastOwner <= OWNER_DMA;
            accWe     <= 1'b0;
            errFlag   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            state <= stateNext;
            if (grantNow) begin
                owner <= reqOwner;
                if (reqOwner == OWNER_CPU) begin
                    accWe     <= cpu_we;
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                end else begin
                    accWe     <= dma_we;
                    mem_addr  <= dma_addr;
                    mem_wdata <= dma_wdata;
                end
            end
            if (complete) begin
                errFlag <= 1'b0;
                if (!accWe) begin
                    if (owner == OWNER_CPU) cpu_rdata <= mem_rdata;
                    else                    dma_rdata <= mem_rdata;
                end
            end
            if (abort) begin
                errFlag <= 1'b1;
                if (owner == OWNER_CPU) cpu_rdata <= ERR_DATA;
                else                    dma_rdata <= ERR_DATA;
            end
            if (state == DONE) begin
                lastOwner <= owner;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign cpu_grant = busy && (owner == OWNER_CPU);
    assign dma_grant = busy && (owner == OWNER_DMA);
    assign mem_re    = (state == ACCESS) && !accWe;
    assign mem_we    = (state == ACCESS) && accWe;
    assign cpu_ready = (state == DONE) && !errFlag && (owner == OWNER_CPU);
    assign dma_ready = (state == DONE) && !errFlag && (owner == OWNER_DMA);
    assign cpu_err   = (state == DONE) && errFlag && (owner == OWNER_CPU);
    assign dma_err   = (state == DONE) && errFlag && (owner == OWNER_DMA);

endmodule
